// File: rtl/cva6_lsu_mem_responder.sv
// Memory-side responder for the CVA6 LSU benches: queues loads and stores separately
// and returns a one-cycle response pulse per request after a fixed latency.
module cva6_lsu_mem_responder #(
    parameter int ADDR_W        = 32,
    parameter int DEPTH         = 4,
    parameter int LOAD_LATENCY  = 3,
    parameter int STORE_LATENCY = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    input  logic                       req_is_load_i,
    input  logic [ADDR_W-1:0]          req_addr_i,
    output logic                       req_ready_o,
    output logic                       load_mem_resp_o,
    output logic [ADDR_W-1:0]          load_resp_addr_o,
    output logic                       store_mem_resp_o,
    output logic [ADDR_W-1:0]          store_resp_addr_o,
    output logic [$clog2(DEPTH+1)-1:0] load_pending_o,
    output logic [$clog2(DEPTH+1)-1:0] store_pending_o,
    output logic                       overflow_o
);

    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int MAX_LAT = (LOAD_LATENCY > STORE_LATENCY) ? LOAD_LATENCY : STORE_LATENCY;
    localparam int DW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [DW-1:0] LOAD_CD  = DW'(LOAD_LATENCY - 1);
    localparam logic [DW-1:0] STORE_CD = DW'(STORE_LATENCY - 1);

    logic [ADDR_W-1:0] ld_addr_q [DEPTH];
    logic [DW-1:0]     ld_cd_q   [DEPTH];
    logic [DEPTH-1:0]  ld_vld_q;
    logic [PW-1:0]     ld_rd_q;
    logic [PW-1:0]     ld_wr_q;
    logic [CW-1:0]     ld_cnt_q;

    logic [ADDR_W-1:0] st_addr_q [DEPTH];
    logic [DW-1:0]     st_cd_q   [DEPTH];
    logic [DEPTH-1:0]  st_vld_q;
    logic [PW-1:0]     st_rd_q;
    logic [PW-1:0]     st_wr_q;
    logic [CW-1:0]     st_cnt_q;

    logic accept;
    logic ld_push_req;
    logic st_push_req;
    logic ld_push;
    logic st_push;
    logic ld_pop;
    logic st_pop;
    logic ld_bypass;
    logic st_bypass;
    logic ld_hazard;
    logic byp_hazard;

    assign req_ready_o    = (ld_cnt_q < FULL) && (st_cnt_q < FULL);
    assign accept         = req_valid_i && req_ready_o;
    assign ld_push_req    = accept && req_is_load_i;
    assign st_push_req    = accept && !req_is_load_i;
    assign load_pending_o  = ld_cnt_q;
    assign store_pending_o = st_cnt_q;

    // A load is held back while any queued store (including one retiring now) targets its address.
    always_comb begin
        ld_hazard  = 1'b0;
        byp_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (st_vld_q[i] && (st_addr_q[i] == ld_addr_q[ld_rd_q])) begin
                ld_hazard = 1'b1;
            end
            if (st_vld_q[i] && (st_addr_q[i] == req_addr_i)) begin
                byp_hazard = 1'b1;
            end
        end
    end

    // A head retires on the edge its countdown expires; latency 1 bypasses an empty queue.
    assign ld_pop    = (ld_cnt_q != '0) && (ld_cd_q[ld_rd_q] <= DW'(1)) && !ld_hazard;
    assign st_pop    = (st_cnt_q != '0) && (st_cd_q[st_rd_q] <= DW'(1));
    assign ld_bypass = ld_push_req && (LOAD_LATENCY == 1) && (ld_cnt_q == '0) && !byp_hazard;
    assign st_bypass = st_push_req && (STORE_LATENCY == 1) && (st_cnt_q == '0);
    assign ld_push   = ld_push_req && !ld_bypass;
    assign st_push   = st_push_req && !st_bypass;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                ld_addr_q[i] <= '0;
                ld_cd_q[i]   <= '0;
            end
            ld_vld_q <= '0;
            ld_rd_q  <= '0;
            ld_wr_q  <= '0;
            ld_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ld_vld_q[i] && (ld_cd_q[i] != '0)) begin
                    ld_cd_q[i] <= ld_cd_q[i] - DW'(1);
                end
            end
            if (ld_pop) begin
                ld_vld_q[ld_rd_q] <= 1'b0;
                ld_rd_q           <= ld_rd_q + PW'(1);
            end
            if (ld_push) begin
                ld_vld_q[ld_wr_q]  <= 1'b1;
                ld_addr_q[ld_wr_q] <= req_addr_i;
                ld_cd_q[ld_wr_q]   <= LOAD_CD;
                ld_wr_q            <= ld_wr_q + PW'(1);
            end
            ld_cnt_q <= ld_cnt_q + CW'(ld_push) - CW'(ld_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                st_addr_q[i] <= '0;
                st_cd_q[i]   <= '0;
            end
            st_vld_q <= '0;
            st_rd_q  <= '0;
            st_wr_q  <= '0;
            st_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_vld_q[i] && (st_cd_q[i] != '0)) begin
                    st_cd_q[i] <= st_cd_q[i] - DW'(1);
                end
            end
            if (st_pop) begin
                st_vld_q[st_rd_q] <= 1'b0;
                st_rd_q           <= st_rd_q + PW'(1);
            end
            if (st_push) begin
                st_vld_q[st_wr_q]  <= 1'b1;
                st_addr_q[st_wr_q] <= req_addr_i;
                st_cd_q[st_wr_q]   <= STORE_CD;
                st_wr_q            <= st_wr_q + PW'(1);
            end
            st_cnt_q <= st_cnt_q + CW'(st_push) - CW'(st_pop);
        end
    end

    // Response pulses are registered; the address outputs hold between pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_mem_resp_o   <= 1'b0;
            load_resp_addr_o  <= '0;
            store_mem_resp_o  <= 1'b0;
            store_resp_addr_o <= '0;
            overflow_o        <= 1'b0;
        end else begin
            load_mem_resp_o  <= ld_pop || ld_bypass;
            store_mem_resp_o <= st_pop || st_bypass;
            if (ld_pop) begin
                load_resp_addr_o <= ld_addr_q[ld_rd_q];
            end else if (ld_bypass) begin
                load_resp_addr_o <= req_addr_i;
            end
            if (st_pop) begin
                store_resp_addr_o <= st_addr_q[st_rd_q];
            end else if (st_bypass) begin
                store_resp_addr_o <= req_addr_i;
            end
            if (req_valid_i && !req_ready_o) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cva6_lsu_mem_responder.sv
// Scoreboard bench for cva6_lsu_mem_responder: expected pulse edges are queued at
// stimulus time and checked every cycle by a negedge monitor.
module tb_cva6_lsu_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_is_load;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        load_resp;
    logic [31:0] load_addr;
    logic        store_resp;
    logic [31:0] store_addr;
    logic [2:0]  load_pending;
    logic [2:0]  store_pending;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        int          e;
        logic [31:0] a;
    } exp_t;

    exp_t lq[$];
    exp_t sq[$];

    cva6_lsu_mem_responder #(
        .ADDR_W(32),
        .DEPTH(4),
        .LOAD_LATENCY(3),
        .STORE_LATENCY(6)
    ) u_dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid),
        .req_is_load_i(req_is_load),
        .req_addr_i(req_addr),
        .req_ready_o(req_ready),
        .load_mem_resp_o(load_resp),
        .load_resp_addr_o(load_addr),
        .store_mem_resp_o(store_resp),
        .store_resp_addr_o(store_addr),
        .load_pending_o(load_pending),
        .store_pending_o(store_pending),
        .overflow_o(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Drive one request for one cycle; delay is pop edge minus accept edge, -1 if dropped.
    task automatic applyStimulus(input logic is_load, input logic [31:0] addr, input int delay);
        exp_t ent;
        ent.e = edge_n + 1 + delay;
        ent.a = addr;
        req_valid   = 1'b1;
        req_is_load = is_load;
        req_addr    = addr;
        if (delay >= 0) begin
            if (is_load) lq.push_back(ent);
            else         sq.push_back(ent);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (lq.size() > 0 && lq[0].e < edge_n) begin
                checkOutput("load_missed", 32'(lq[0].e), 32'(edge_n));
                void'(lq.pop_front());
            end
            if (lq.size() > 0 && lq[0].e == edge_n) begin
                checkOutput("load_resp", {31'd0, load_resp}, 32'd1);
                checkOutput("load_addr", load_addr, lq[0].a);
                void'(lq.pop_front());
            end else begin
                checkOutput("load_idle", {31'd0, load_resp}, 32'd0);
            end
            while (sq.size() > 0 && sq[0].e < edge_n) begin
                checkOutput("store_missed", 32'(sq[0].e), 32'(edge_n));
                void'(sq.pop_front());
            end
            if (sq.size() > 0 && sq[0].e == edge_n) begin
                checkOutput("store_resp", {31'd0, store_resp}, 32'd1);
                checkOutput("store_addr", store_addr, sq[0].a);
                void'(sq.pop_front());
            end else begin
                checkOutput("store_idle", {31'd0, store_resp}, 32'd0);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_is_load = 1'b0;
        req_addr    = '0;
        #1;
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_load_resp", {31'd0, load_resp}, 32'd0);
        checkOutput("rst_store_resp", {31'd0, store_resp}, 32'd0);
        checkOutput("rst_load_pend", {29'd0, load_pending}, 32'd0);
        checkOutput("rst_store_pend", {29'd0, store_pending}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single load, latency 3
        applyStimulus(1'b1, 32'hcad, 2);
        checkOutput("t1_load_pend_1", {29'd0, load_pending}, 32'd1);
        idle(4);
        checkOutput("t1_load_pend_0", {29'd0, load_pending}, 32'd0);

        // Single store, latency 6
        applyStimulus(1'b0, 32'hcad, 5);
        checkOutput("t2_store_pend_1", {29'd0, store_pending}, 32'd1);
        idle(8);
        checkOutput("t2_store_pend_0", {29'd0, store_pending}, 32'd0);

        // Store then load to the same address: load waits for the store
        applyStimulus(1'b0, 32'hcad, 5);
        applyStimulus(1'b1, 32'hcad, 5);
        idle(10);

        // Fill the load queue behind a blocking store, then overflow
        applyStimulus(1'b0, 32'h100, 5);
        applyStimulus(1'b1, 32'h100, 5);
        applyStimulus(1'b1, 32'h101, 5);
        applyStimulus(1'b1, 32'h102, 5);
        applyStimulus(1'b1, 32'h103, 5);
        checkOutput("t4_ready_full", {31'd0, req_ready}, 32'd0);
        checkOutput("t4_load_pend_4", {29'd0, load_pending}, 32'd4);
        checkOutput("t4_overflow_pre", {31'd0, overflow}, 32'd0);
        applyStimulus(1'b1, 32'h104, -1);
        checkOutput("t4_overflow", {31'd0, overflow}, 32'd1);
        checkOutput("t4_ready_still_0", {31'd0, req_ready}, 32'd0);
        checkOutput("t4_load_pend_still_4", {29'd0, load_pending}, 32'd4);
        idle(1);
        checkOutput("t4_ready_back", {31'd0, req_ready}, 32'd1);
        idle(8);
        checkOutput("t4_load_pend_0", {29'd0, load_pending}, 32'd0);
        checkOutput("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Load and store retiring in the same cycle
        applyStimulus(1'b0, 32'h20, 5);
        idle(2);
        applyStimulus(1'b1, 32'h10, 2);
        idle(8);

        // Reset with two loads in flight
        applyStimulus(1'b1, 32'h30, 2);
        applyStimulus(1'b1, 32'h31, 2);
        rst_n = 1'b0;
        #1;
        lq.delete();
        sq.delete();
        checkOutput("t6_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("t6_load_pend", {29'd0, load_pending}, 32'd0);
        checkOutput("t6_load_resp", {31'd0, load_resp}, 32'd0);
        checkOutput("t6_overflow", {31'd0, overflow}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(8);
        checkOutput("t6_load_pend_after", {29'd0, load_pending}, 32'd0);

        checkOutput("sb_load_empty", 32'(lq.size()), 32'd0);
        checkOutput("sb_store_empty", 32'(sq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
